// File: rtl/instr_fetch.sv
// Instruction fetch stage: a 16-entry instruction store with a LOAD phase
// (valid/ready write port) followed by a RUN phase that returns the word
// at `pc` one clock later. Slots not written since reset read as NOP and
// are flagged with instr_err.
module instr_fetch #(
   parameter int unsigned        ADDR_W   = 4,
   parameter int unsigned        DATA_W   = 15,
   parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] pc,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_done,
   input  logic              stall,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   output logic              instr_err,
   output logic              running
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   typedef enum logic {
      S_LOAD = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic              wr_en_c;
   logic              fetch_c;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  written_q;

   // State register; reset always returns to LOAD
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and per-cycle write/fetch strobes
   always_comb begin
      state_d = state_q;
      wr_en_c = 1'b0;
      fetch_c = 1'b0;
      case (state_q)
         S_LOAD: begin
            // A beat arriving with ld_done is still written before leaving LOAD
            wr_en_c = ld_valid && ld_ready;
            if (ld_done) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            fetch_c = !stall;
         end
         default: begin
            state_d = S_LOAD;
         end
      endcase
   end

   // Instruction store; contents survive reset, only the flags are cleared
   always_ff @(posedge clk) begin
      if (rst_n && wr_en_c) begin
         mem[ld_addr] <= ld_data;
      end
   end

   // Per-slot written flags; an unflagged slot reads as NOP with error
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         written_q <= '0;
      end else if (wr_en_c) begin
         written_q[ld_addr] <= 1'b1;
      end
   end

   // Registered outputs: handshake/phase status and the 1-cycle fetch
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ld_ready    <= 1'b0;
         running     <= 1'b0;
         instr       <= NOP_WORD;
         instr_valid <= 1'b0;
         instr_err   <= 1'b0;
      end else begin
         ld_ready <= (state_d == S_LOAD);
         running  <= (state_d == S_RUN);
         if (fetch_c) begin
            instr       <= written_q[pc] ? mem[pc] : NOP_WORD;
            instr_err   <= ~written_q[pc];
            instr_valid <= 1'b1;
         end
      end
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-side consumer of the 4-bit program counter. It holds a 16-entry instruction store and returns the instruction at the current PC address one clock later.
- The store is written through a valid/ready load port while the block is in a LOAD phase. The block then switches to RUN and fetches every cycle from `pc`.
- Sits between the PC counter and the decode/execute stage.

Parameters:
- ADDR_W, 4, address width; must match the PC width. Depth = 2**ADDR_W = 16 entries.
- DATA_W, 15, instruction word width.
- NOP_WORD, 0, word driven on `instr` for unwritten or empty slots.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- pc  in  ADDR_W  fetch address from the program counter.
- ld_valid  in  1  load beat present.
- ld_ready  out  1  block can accept a load beat.
- ld_addr  in  ADDR_W  store address for the load beat.
- ld_data  in  DATA_W  instruction word for the load beat.
- ld_done  in  1  end of program load; request switch to RUN.
- stall  in  1  downstream hold; freezes fetch outputs.
- instr  out  DATA_W  fetched instruction (registered).
- instr_valid  out  1  `instr` holds a fetched word.
- instr_err  out  1  fetched slot was never written since the last reset.
- running  out  1  state == RUN.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=LOAD.
  - written-flag vector (16 bits) cleared.
  - instr=NOP_WORD, instr_valid=0, instr_err=0, running=0.
  - ld_ready=0 during the reset cycle; ld_ready=1 from the first cycle after reset.
  - Store contents are not reset; the cleared flags make them unreadable.
- State LOAD:
  - ld_ready=1.
  - Beat accepted when ld_valid && ld_ready at the edge: mem[ld_addr]<=ld_data and flag[ld_addr]<=1.
  - A rewrite of the same address overwrites; last write wins.
  - instr_valid stays 0; `pc` is ignored.
  - ld_done=1 at an edge moves to RUN. If ld_valid is also 1 in that cycle, the beat is written first, then the transition occurs.
  - ld_done with no prior writes is legal: RUN then fetches NOP with err=1 everywhere.
- State RUN:
  - ld_ready=0; ld_valid, ld_addr, ld_data and ld_done are ignored.
  - running=1 from the first cycle after the transition edge.
  - Each edge with stall=0: instr<=flag[pc] ? mem[pc] : NOP_WORD; instr_err<=~flag[pc]; instr_valid<=1.
  - Latency is exactly 1 cycle from the `pc` value to `instr`.
  - The first instr_valid=1 appears 1 cycle after running rises. The edge that enters RUN performs no fetch.
  - stall=1 at an edge: instr, instr_valid and instr_err hold their values. No fetch occurs; the pc value in that cycle is dropped.
  - PC wrap-around 15->0 needs no special handling; slot 0 is fetched normally.
- There is no RUN->LOAD transition other than reset. Reset mid-RUN (including during stall) returns to LOAD with all flags cleared, so the program must be reloaded.
- rst_n=0 overrides every other input in the same cycle.
- X-free outputs: every output has a defined value from the first post-reset cycle.

Test Plan:
1. Reset, load mem[0..3]=0x0011,0x0022,0x0033,0x0044 with ld_valid held high, pulse ld_done, then drive pc=0,1,2,3 on consecutive cycles -> instr=0x0011,0x0022,0x0033,0x0044 one cycle after each pc, instr_valid=1, instr_err=0. ld_ready=1 throughout LOAD and 0 after.
2. Load only mem[5]=0x7ABC, run, pc=4 then pc=5 -> instr=0x0000 with instr_err=1, then instr=0x7ABC with instr_err=0.
3. Same-cycle ld_valid=1 (addr 2, data 0x1234) with ld_done=1, then fetch pc=2 -> instr=0x1234, instr_err=0. A later ld_valid in RUN (addr 2, data 0x5555) has no effect; re-fetching pc=2 still returns 0x1234.
4. In RUN with valid output 0x0022 (pc=1), assert stall for 3 cycles while pc moves 2,3,4 -> instr stays 0x0022 and instr_valid stays 1. Deassert stall with pc=4 -> next cycle shows mem[4] or NOP with err.
5. Full load of 16 slots with value 0x100+i, run with pc counting 0..15,0,1 -> instr = 0x100..0x10F, then 0x100 and 0x101 on the wrap, no error flagged.
6. Assert rst_n=0 for one cycle mid-RUN, then with no reload pulse ld_done and fetch pc=0 -> instr=0x0000, instr_err=1. Also check running=0, instr_valid=0 and ld_ready=0 in the cycle after the reset edge, and ld_ready=1 one cycle later.
